// File: rtl/timer_dev_if.sv
// timer_dev_if
// Bus bundle between the processor-to-peripheral bridge and one timer
// instance.
//   Addr  device address from the bridge (only [3:2] matter to the timer)
//   We    write enable, asserted only when this timer is the target
//   Din   write data from the bridge
//   Dout  combinational read data of the addressed register
//   IRQ   registered interrupt request
// The master modport is the bridge side and the slave modport is the timer
// side.
interface timer_dev_if;
  logic [3:0]  Addr;
  logic        We;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  modport master (output Addr, We, Din, input Dout, IRQ);
  modport slave  (input Addr, We, Din, output Dout, IRQ);
endinterface

// File: rtl/timer_dev.sv
// timer_dev
// Programmable countdown timer on the device side of the bridge. It has three
// registers, selected by bus.Addr[3:2]:
//   00 CTRL   (rw) [0] EN, [2:1] MODE (01 = auto-reload, else one-shot),
//                  [3] IM (1 = IRQ allowed); the upper bits read as 0.
//   01 PRESET (rw) reload value
//   10 COUNT  (ro) current count
//   11 reserved, reads 0
// When the count expires the timer sets an internal pending flag. IRQ is the
// pending flag ANDed with IM, and it is registered.
// Ports:
//   clk    system clock; all state changes on the rising edge
//   reset  synchronous, active-high
//   bus    timer_dev_if.slave (Addr, We, Din, Dout, IRQ)
module timer_dev (
  input  logic        clk,
  input  logic        reset,
  timer_dev_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} stateType;

  localparam logic [1:0] AddrCtrl   = 2'b00;
  localparam logic [1:0] AddrPreset = 2'b01;
  localparam logic [1:0] AddrCount  = 2'b10;

  stateType    state;
  logic [3:0]  ctrlReg;
  logic [31:0] presetReg;
  logic [31:0] countReg;
  logic        pend;
  logic        irqReg;

  logic        writeCtrl;
  logic        writePreset;
  logic        autoReload;

  // The timer decodes only a word-aligned register index. The byte-offset
  // bits are folded into this signal so that they are visibly consumed.
  logic        unusedAddrBits;
  assign unusedAddrBits = ^bus.Addr[1:0];

  assign writeCtrl   = bus.We && (bus.Addr[3:2] == AddrCtrl);
  assign writePreset = bus.We && (bus.Addr[3:2] == AddrPreset);
  assign autoReload  = (ctrlReg[2:1] == 2'b01);

  // The FSM and the register file share one sequential block. The FSM
  // updates come first and the CPU writes come last. This way a CPU write
  // beats an FSM update of the same register in the same cycle, including
  // the EN clear in INT. Every decision reads the pre-edge register values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ctrlReg   <= 4'd0;
      presetReg <= 32'd0;
      countReg  <= 32'd0;
      pend      <= 1'b0;
      irqReg    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ctrlReg[0]) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          countReg <= presetReg;
          state    <= CNT;
        end
        CNT: begin
          if (!ctrlReg[0]) begin
            state <= IDLE;
          end else if (countReg <= 32'd1) begin
            // A count of 0 or 1 expires here, so COUNT never wraps.
            countReg <= 32'd0;
            pend     <= 1'b1;
            state    <= INT;
          end else begin
            countReg <= countReg - 32'd1;
          end
        end
        INT: begin
          if (autoReload) begin
            pend  <= 1'b0;
            state <= LOAD;
          end else begin
            // In one-shot mode pend stays set until software writes
            // CTRL or PRESET.
            ctrlReg[0] <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      irqReg <= pend & ctrlReg[3];

      if (writeCtrl) begin
        ctrlReg <= bus.Din[3:0];
        pend    <= 1'b0;
      end
      if (writePreset) begin
        presetReg <= bus.Din;
        pend      <= 1'b0;
      end
    end
  end

  // The read mux is combinational in Addr and the current register values.
  always_comb begin
    bus.Dout = 32'd0;
    case (bus.Addr[3:2])
      AddrCtrl:   bus.Dout = {28'd0, ctrlReg};
      AddrPreset: bus.Dout = presetReg;
      AddrCount:  bus.Dout = countReg;
      default:    bus.Dout = 32'd0;
    endcase
  end

  assign bus.IRQ = irqReg;

endmodule
